// File: rtl/lambo_pkg.sv
// Shared definitions for the register-file write arbiter.
//   N          : number of write requesters
//   LOCK_LIMIT : locked transfers allowed before the lock is force-released
//   req_id_e   : requester identities, in index order
//   lock_st_e  : arbiter lock state
package lambo_pkg;

   localparam int unsigned N          = 3;
   localparam int unsigned LOCK_LIMIT = 4;

   typedef enum logic [1:0] {
      REQ_ALU   = 2'd0,
      REQ_LOAD  = 2'd1,
      REQ_SHIFT = 2'd2
   } req_id_e;

   typedef enum logic {
      LOCK_FREE,
      LOCK_HELD
   } lock_st_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotate-priority selector: picks the first set request at or after Ptr,
// in index order, wrapping from N-1 back to 0. Purely combinational.
//   Req      : request vector
//   Ptr      : round-robin start index (0..N-1)
//   Grant    : one-hot grant (all zeros when no request)
//   GrantIdx : index of the granted request (0 when none)
//   Found    : at least one request was set
module rr_priority_picker #(
   parameter int unsigned N = 3
) (
   input  logic [N-1:0] Req,
   input  logic [1:0]   Ptr,
   output logic [N-1:0] Grant,
   output logic [1:0]   GrantIdx,
   output logic         Found
);

   int unsigned idx;
   logic [1:0]  idxSel;

   always_comb begin
      Grant    = '0;
      GrantIdx = '0;
      Found    = 1'b0;
      idx      = 0;
      idxSel   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = {30'd0, Ptr} + k;
         if (idx >= N) idx = idx - N;
         idxSel = idx[1:0];
         if (!Found && Req[idxSel]) begin
            Found         = 1'b1;
            Grant[idxSel] = 1'b1;
            GrantIdx      = idxSel;
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with per-requester
// burst locking and a registered write port.
//   Clk, Reset(active-low, synchronous), Start(synchronous flush)
//   ReqValid/ReqAddr/ReqData/ReqLock : per-requester request bundle
//   ReqReady    : one-hot combinational grant
//   WriteEn/Waddr/WrData : register-file write port, one cycle after transfer
//   GrantId     : index of the last granted requester
//   ConflictCnt : saturating count of cycles with two or more requests
module reg_write_arbiter #(
   parameter int unsigned W = 8,
   parameter int unsigned D = 4,
   parameter int unsigned N = 3
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic [N-1:0]   ReqValid,
   input  logic [N*D-1:0] ReqAddr,
   input  logic [N*W-1:0] ReqData,
   input  logic [N-1:0]   ReqLock,
   output logic [N-1:0]   ReqReady,
   output logic           WriteEn,
   output logic [D-1:0]   Waddr,
   output logic [W-1:0]   WrData,
   output logic [1:0]     GrantId,
   output logic [7:0]     ConflictCnt
);

   import lambo_pkg::*;

   lock_st_e   state, nextState;
   logic [1:0] owner, nextOwner;
   logic [1:0] ptr, nextPtr;
   logic [2:0] burst, nextBurst, baseBurst;
   logic [1:0] grantIdx;
   logic       holding;
   logic       xfer;
   logic       multi;

   logic [N-1:0] pickGrant;
   logic [1:0]   pickIdx;
   logic         pickFound;

   rr_priority_picker #(.N(N)) uPicker (
      .Req      (ReqValid),
      .Ptr      (ptr),
      .Grant    (pickGrant),
      .GrantIdx (pickIdx),
      .Found    (pickFound)
   );

   assign multi = ($countones(ReqValid) >= 2);

   always_comb begin
      ReqReady  = '0;
      nextState = state;
      nextOwner = owner;
      nextBurst = burst;
      nextPtr   = ptr;
      grantIdx  = pickIdx;
      baseBurst = '0;
      xfer      = 1'b0;

      // A held lock only survives while its owner keeps requesting; once the
      // owner drops out, normal round-robin arbitration applies this cycle.
      holding = (state == LOCK_HELD) && ReqValid[owner];
      if (holding) begin
         ReqReady[owner] = 1'b1;
         grantIdx        = owner;
         baseBurst       = burst;
      end else if (pickFound) begin
         ReqReady = pickGrant;
      end

      if (!Reset || Start) ReqReady = '0;
      xfer = |ReqReady;

      if (xfer) begin
         // The LOCK_LIMIT-th consecutive locked beat is treated as unlocked.
         if (ReqLock[grantIdx] && ({29'd0, baseBurst} + 32'd1 < LOCK_LIMIT)) begin
            nextState = LOCK_HELD;
            nextOwner = grantIdx;
            nextBurst = baseBurst + 3'd1;
         end else begin
            nextState = LOCK_FREE;
            nextBurst = '0;
            nextPtr   = (grantIdx == 2'(N - 1)) ? 2'd0 : grantIdx + 2'd1;
         end
      end else begin
         nextState = LOCK_FREE;
         nextBurst = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= LOCK_FREE;
         owner <= '0;
         burst <= '0;
         ptr   <= '0;
      end else if (Start) begin
         state <= LOCK_FREE;
         owner <= '0;
         burst <= '0;
         ptr   <= '0;
      end else begin
         state <= nextState;
         owner <= nextOwner;
         burst <= nextBurst;
         ptr   <= nextPtr;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         WriteEn     <= 1'b0;
         Waddr       <= '0;
         WrData      <= '0;
         GrantId     <= REQ_ALU;
         ConflictCnt <= '0;
      end else if (Start) begin
         WriteEn     <= 1'b0;
         ConflictCnt <= '0;
      end else begin
         WriteEn <= xfer;
         if (xfer) begin
            Waddr   <= ReqAddr[grantIdx*D +: D];
            WrData  <= ReqData[grantIdx*W +: W];
            GrantId <= grantIdx;
         end
         if (multi && (ConflictCnt != 8'hFF)) ConflictCnt <= ConflictCnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

   logic        Clk;
   logic        rstN;
   logic        start;
   logic [2:0]  valid;
   logic [11:0] addr;
   logic [23:0] data;
   logic [2:0]  lock;
   logic [2:0]  ReqReady;
   logic        WriteEn;
   logic [3:0]  Waddr;
   logic [7:0]  WrData;
   logic [1:0]  GrantId;
   logic [7:0]  ConflictCnt;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int         mPtr, mOwner, mBurst, mCnt;
   logic       mWe;
   logic [3:0] mAddr;
   logic [7:0] mData;
   logic [1:0] mGid;

   reg_write_arbiter #(.W(8), .D(4), .N(3)) dut (
      .Clk         (Clk),
      .Reset       (rstN),
      .Start       (start),
      .ReqValid    (valid),
      .ReqAddr     (addr),
      .ReqData     (data),
      .ReqLock     (lock),
      .ReqReady    (ReqReady),
      .WriteEn     (WriteEn),
      .Waddr       (Waddr),
      .WrData      (WrData),
      .GrantId     (GrantId),
      .ConflictCnt (ConflictCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [2:0] oneHot(input int g);
      logic [2:0] r;
      r = 3'b000;
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   // Who should be granted right now, from the arbitration rules.
   function automatic int modelGrant();
      if (!rstN || start) return -1;
      if (mOwner >= 0 && valid[mOwner]) return mOwner;
      for (int k = 0; k < 3; k++) begin
         if (valid[(mPtr + k) % 3]) return (mPtr + k) % 3;
      end
      return -1;
   endfunction

   function automatic void modelUpdate();
      int g;
      int b;
      g = modelGrant();
      if (!rstN) begin
         mPtr = 0; mOwner = -1; mBurst = 0; mCnt = 0;
         mWe = 1'b0; mAddr = '0; mData = '0; mGid = '0;
      end else if (start) begin
         mPtr = 0; mOwner = -1; mBurst = 0; mCnt = 0; mWe = 1'b0;
      end else begin
         if ($countones(valid) >= 2 && mCnt < 255) mCnt++;
         if (g < 0) begin
            mWe = 1'b0; mOwner = -1; mBurst = 0;
         end else begin
            mWe   = 1'b1;
            mAddr = addr[g*4 +: 4];
            mData = data[g*8 +: 8];
            mGid  = g[1:0];
            b = (g == mOwner) ? mBurst + 1 : 1;
            if (lock[g] && b < 4) begin
               mOwner = g; mBurst = b;
            end else begin
               mOwner = -1; mBurst = 0; mPtr = (g + 1) % 3;
            end
         end
      end
   endfunction

   task automatic drive(input logic r, input logic s, input logic [2:0] v,
                        input logic [2:0] l, input logic [11:0] a, input logic [23:0] d);
      @(negedge Clk);
      rstN = r; start = s; valid = v; lock = l; addr = a; data = d;
      #1;
   endtask

   task automatic step();
      @(posedge Clk);
      modelUpdate();
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 3'b111, 3'b111, $urandom, $urandom);
         checks++;
         if (ReqReady !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b want 000", ReqReady);
         end
         step();
         checks++;
         if ({WriteEn, Waddr, WrData, GrantId, ConflictCnt} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h gid=%0d cnt=%0d want all 0",
                     WriteEn, Waddr, WrData, GrantId, ConflictCnt);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] a;
      logic [23:0] d;
      a = $urandom; d = $urandom;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 3'b111, 3'b000, a, d);
         checks++;
         if (ReqReady !== oneHot(i)) begin
            errors++; $display("FAIL rr_ready%0d: got %b want %b", i, ReqReady, oneHot(i));
         end
         step();
         checks++;
         if (WriteEn !== 1'b1 || GrantId !== 2'(i) || Waddr !== a[i*4 +: 4] || WrData !== d[i*8 +: 8]) begin
            errors++;
            $display("FAIL rr_write%0d: we=%b gid=%0d addr=%h data=%h want 1 %0d %h %h",
                     i, WriteEn, GrantId, Waddr, WrData, i, a[i*4 +: 4], d[i*8 +: 8]);
         end
      end
      checks++;
      if (ConflictCnt !== 8'd3) begin
         errors++; $display("FAIL rr_conflict: got %0d want 3", ConflictCnt);
      end
      drive(1'b1, 1'b0, 3'b000, 3'b000, $urandom, $urandom);
      step();
      checks++;
      if (WriteEn !== 1'b0 || GrantId !== 2'd2 || Waddr !== a[11:8]) begin
         errors++; $display("FAIL idle_hold: we=%b gid=%0d addr=%h want 0 2 %h", WriteEn, GrantId, Waddr, a[11:8]);
      end
   endtask

   task automatic test_single();
      logic [11:0] a;
      logic [23:0] d;
      a = $urandom; d = $urandom;
      a[7:4] = 4'd5; d[15:8] = 8'hA3;
      drive(1'b1, 1'b0, 3'b010, 3'b000, a, d);
      checks++;
      if (ReqReady !== 3'b010) begin
         errors++; $display("FAIL single_ready: got %b want 010", ReqReady);
      end
      step();
      checks++;
      if (WriteEn !== 1'b1 || Waddr !== 4'd5 || WrData !== 8'hA3 || GrantId !== 2'd1) begin
         errors++; $display("FAIL single_write: we=%b addr=%0d data=%h gid=%0d want 1 5 a3 1",
                            WriteEn, Waddr, WrData, GrantId);
      end
   endtask

   task automatic test_lock();
      int exp [6] = '{2, 2, 2, 2, 0, 2};
      drive(1'b1, 1'b1, 3'b000, 3'b000, '0, '0);
      step();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, (i == 0) ? 3'b100 : 3'b101, 3'b100, $urandom, $urandom);
         checks++;
         if (ReqReady !== oneHot(exp[i])) begin
            errors++; $display("FAIL lock_ready%0d: got %b want %b", i, ReqReady, oneHot(exp[i]));
         end
         step();
         checks++;
         if (WriteEn !== 1'b1 || GrantId !== 2'(exp[i])) begin
            errors++; $display("FAIL lock_grant%0d: we=%b gid=%0d want 1 %0d", i, WriteEn, GrantId, exp[i]);
         end
      end
      // Owner 2 is now locked; it drops its request and 0 must win.
      drive(1'b1, 1'b0, 3'b001, 3'b000, $urandom, $urandom);
      checks++;
      if (ReqReady !== 3'b001) begin
         errors++; $display("FAIL lock_drop: got %b want 001", ReqReady);
      end
      step();
   endtask

   task automatic test_start();
      drive(1'b1, 1'b0, 3'b011, 3'b000, $urandom, $urandom);
      step();
      checks++;
      if (WriteEn !== 1'b1 || ConflictCnt === 8'd0) begin
         errors++; $display("FAIL start_pre: we=%b cnt=%0d want we=1 cnt>0", WriteEn, ConflictCnt);
      end
      drive(1'b1, 1'b1, 3'b011, 3'b011, $urandom, $urandom);
      checks++;
      if (ReqReady !== 3'b000) begin
         errors++; $display("FAIL start_ready: got %b want 000", ReqReady);
      end
      step();
      checks++;
      if (WriteEn !== 1'b0 || ConflictCnt !== 8'd0) begin
         errors++; $display("FAIL start_flush: we=%b cnt=%0d want 0 0", WriteEn, ConflictCnt);
      end
      drive(1'b1, 1'b0, 3'b110, 3'b000, $urandom, $urandom);
      step();
      drive(1'b1, 1'b1, 3'b000, 3'b000, $urandom, $urandom);
      step();
      drive(1'b1, 1'b0, 3'b111, 3'b000, $urandom, $urandom);
      checks++;
      if (ReqReady !== 3'b001) begin
         errors++; $display("FAIL start_ptr: got %b want 001", ReqReady);
      end
      step();
   endtask

   task automatic test_saturate();
      drive(1'b1, 1'b1, 3'b000, 3'b000, '0, '0);
      step();
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 1'b0, 3'b111, 3'b000, $urandom, $urandom);
         step();
         if (i == 253) begin
            checks++;
            if (ConflictCnt !== 8'd254) begin
               errors++; $display("FAIL sat_254: got %0d want 254", ConflictCnt);
            end
         end
      end
      checks++;
      if (ConflictCnt !== 8'd255) begin
         errors++; $display("FAIL sat_255: got %0d want 255", ConflictCnt);
      end
   endtask

   task automatic test_reset_midlock();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 3'b010, 3'b010, $urandom, $urandom);
         step();
      end
      drive(1'b0, 1'b1, 3'b010, 3'b010, $urandom, $urandom);
      checks++;
      if (ReqReady !== 3'b000) begin
         errors++; $display("FAIL midlock_ready: got %b want 000", ReqReady);
      end
      step();
      checks++;
      if ({WriteEn, Waddr, WrData, GrantId, ConflictCnt} !== 23'd0) begin
         errors++;
         $display("FAIL midlock_outputs: we=%b addr=%h data=%h gid=%0d cnt=%0d want all 0",
                  WriteEn, Waddr, WrData, GrantId, ConflictCnt);
      end
      drive(1'b1, 1'b0, 3'b111, 3'b000, $urandom, $urandom);
      checks++;
      if (ReqReady !== 3'b001) begin
         errors++; $display("FAIL midlock_first: got %b want 001", ReqReady);
      end
      step();
      checks++;
      if (WriteEn !== 1'b1 || GrantId !== 2'd0) begin
         errors++; $display("FAIL midlock_write: we=%b gid=%0d want 1 0", WriteEn, GrantId);
      end
   endtask

   task automatic test_random();
      logic [2:0] want;
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 49) != 0, $urandom_range(0, 24) == 0,
               3'($urandom), 3'($urandom), 12'($urandom), 24'($urandom));
         want = oneHot(modelGrant());
         checks++;
         if (ReqReady !== want) begin
            errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ReqReady, want);
         end
         step();
         checks++;
         if (WriteEn !== mWe || Waddr !== mAddr || WrData !== mData ||
             GrantId !== mGid || ConflictCnt !== 8'(mCnt)) begin
            errors++;
            $display("FAIL rand_out[%0d]: we=%b addr=%h data=%h gid=%0d cnt=%0d want %b %h %h %0d %0d",
                     i, WriteEn, Waddr, WrData, GrantId, ConflictCnt, mWe, mAddr, mData, mGid, mCnt);
         end
      end
   endtask

   initial begin
      rstN = 1'b0; start = 1'b0; valid = '0; lock = '0; addr = '0; data = '0;
      mPtr = 0; mOwner = -1; mBurst = 0; mCnt = 0;
      mWe = 1'b0; mAddr = '0; mData = '0; mGid = '0;
      test_reset();
      test_round_robin();
      test_single();
      test_lock();
      test_start();
      test_saturate();
      test_reset_midlock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
